mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequential memory-stage controller between the EX stage and the DPI-backed load/store unit.
- Accepts one request at a time over valid/ready and runs the memory access over a fixed latency.
- Shifts store data into byte lane position. Generates the unshifted byte mask; the LSU shifts the mask itself.
- Sign/zero-extends lane-aligned load data and hands a writeback packet to WB over valid/ready.

Parameters:
MEM_LAT, 1, cycles spent in ACCESS per memory op; legal range 1..15.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
in_valid  input  1  EX request valid
in_ready  output  1  block can accept a request
in_addr  input  64  effective address, or ALU result for non-mem ops
in_wdata  input  64  store data, right-justified
in_is_load  input  1  load op
in_is_store  input  1  store op; never asserted together with in_is_load
in_size  input  2  0=B, 1=H, 2=W, 3=D
in_unsigned  input  1  zero-extend load result
in_rd  input  5  destination register
mem_raddr  output  64  read address to LSU
mem_rdata  input  64  LSU read data, already right-aligned to bit 0
mem_ren  output  1  read active
mem_waddr  output  64  write address to LSU
mem_wdata  output  64  lane-shifted store data
mem_wmask  output  8  unshifted byte mask; 0 when not writing
mem_wen  output  1  write strobe
out_valid  output  1  WB packet valid
out_ready  input  1  WB accepts packet
out_data  output  64  load result or passed-through in_addr
out_rd  output  5  destination register
out_wen  output  1  register-file write enable
out_misalign  output  1  request was misaligned; no access performed

Behaviour:
- Reset values: state=IDLE, counter=0, in_ready=0 during reset cycle then 1. All other outputs are 0, including mem_wen, mem_ren, mem_wmask, out_valid, out_data, out_rd, out_wen and out_misalign.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch addr, wdata, size, unsigned, rd, load and store flags.
  - Alignment rule: misaligned = (size==1 && addr[0]) || (size==2 && addr[1:0]!=0) || (size==3 && addr[2:0]!=0).
  - Non-mem op, or misaligned mem op -> RESP.
  - Aligned mem op -> ACCESS, with counter=MEM_LAT-1.
- State ACCESS:
  - in_ready=0.
  - mem_raddr=mem_waddr=latched addr.
  - Load: mem_ren=1 for every ACCESS cycle.
  - Store: mem_wen=1 and mem_wmask=(1<<(1<<size))-1 only in the cycle where counter==0, so exactly one write strobe per store. mem_wmask=0 in all other cycles.
  - mem_wdata = wdata << (addr[2:0]*8), truncated to 64 bits.
  - counter!=0: decrement.
  - counter==0: register the result, go to RESP.
  - Load result: mem_rdata truncated to 8/16/32/64 bits by size, then zero-extended if unsigned, else sign-extended from the top bit of the truncated field.
  - in_unsigned is ignored for size 3.
- State RESP:
  - out_valid=1. Outputs are held stable until out_ready.
  - On out_valid&&out_ready -> IDLE. No same-cycle accept of a new request; in_ready rises the next cycle.
- Output packet rules:
  - Non-mem op: out_data=latched addr, out_wen=(rd!=0).
  - Load: out_data=extended result, out_wen=(rd!=0).
  - Store: out_data=0, out_wen=0.
  - Misaligned: out_misalign=1, out_wen=0, out_data=latched addr; mem_ren/mem_wen never asserted.
- Latency, accept at edge T:
  - Non-mem or misaligned: out_valid from cycle T+1.
  - Mem op: out_valid from cycle T+1+MEM_LAT.
- Stall: memory access is never repeated while RESP is stalled by out_ready=0.
- Reset mid-operation: mem_wen and mem_ren are gated with reset, so no write is issued in the reset cycle. The next state is IDLE and any in-flight request is discarded.
- If in_is_load and in_is_store are both asserted, the request is treated as a load.
- Addresses are used as given; no wrap or range checking.

Test Plan:
- MEM_LAT=1, LB addr=0x80000003, mem_rdata=0x80, accept at T -> mem_ren=1 in T+1; out_valid in T+2 with out_data=0xFFFFFFFFFFFFFF80, out_wen=1. Same with in_unsigned=1 -> out_data=0x80.
- SH addr=0x80000006, wdata=0x1234 -> mem_wdata=0x1234000000000000, mem_wmask=0x03, mem_wen high exactly one cycle; out_valid with out_wen=0.
- LW addr=0x80000002 -> no mem_ren or mem_wen; out_valid at T+1 with out_misalign=1, out_wen=0, out_data=0x80000002.
- MEM_LAT=3 LD, out_ready held low 4 cycles after out_valid -> out_data stable, in_ready=0, mem_ren low throughout RESP; accept on out_ready, in_ready=1 the next cycle.
- MEM_LAT=4 SD, reset driven low during the 2nd ACCESS cycle -> mem_wen never asserted, all outputs at reset values; a new request is accepted normally after reset is released.
- Non-mem op addr=0xDEAD, rd=5 -> out_data=0xDEAD, out_wen=1 at T+1. Same with rd=0 -> out_wen=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose: memory-stage controller; takes one EX request, runs a fixed-latency
//          LSU access (store lane shift, byte mask, load extension) and hands
//          the result to WB.
// Latency: non-mem/misaligned -> out_valid 1 cycle after accept; mem op -> 1+MEM_LAT.
// Backpressure: one request in flight; in_ready low outside IDLE; RESP holds the
//          packet stable until out_ready, with no re-access of memory while stalled.
//
// Ports:
//   clock, reset           system clock, synchronous active-low reset
//   in_*                   EX request (valid/ready handshake)
//   mem_*                  LSU interface (read data returns in the same cycle)
//   out_*                  WB packet (valid/ready handshake)
module mem_access_ctrl #(
    parameter int MEM_LAT = 1       // cycles spent in ACCESS, legal range 1..15
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [4:0]  in_rd,

    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata,
    output logic        mem_ren,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state;
    logic [3:0]  cnt;

    // Request captured at accept time
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        load_q;
    logic        store_q;
    logic [4:0]  rd_q;

    // Decode of the incoming request
    logic        req_load;
    logic        req_store;
    logic        req_misalign;
    logic        accept;

    // Datapath helpers
    logic [63:0] load_ext;
    logic [7:0]  store_mask;
    logic        in_access;

    // A request flagged as both load and store is handled as a load.
    assign req_load  = in_is_load;
    assign req_store = in_is_store && !in_is_load;

    always_comb begin
        req_misalign = 1'b0;
        case (in_size)
            2'd1:    req_misalign = in_addr[0];
            2'd2:    req_misalign = (in_addr[1:0] != 2'b00);
            2'd3:    req_misalign = (in_addr[2:0] != 3'b000);
            default: req_misalign = 1'b0;
        endcase
    end

    assign in_ready = reset && (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Load data arrives right-aligned; truncate to the access size and extend.
    // Size 3 fills the full word, so the unsigned flag has no effect there.
    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            2'd0: load_ext = unsigned_q ? {56'd0, mem_rdata[7:0]}
                                        : {{56{mem_rdata[7]}}, mem_rdata[7:0]};
            2'd1: load_ext = unsigned_q ? {48'd0, mem_rdata[15:0]}
                                        : {{48{mem_rdata[15]}}, mem_rdata[15:0]};
            2'd2: load_ext = unsigned_q ? {32'd0, mem_rdata[31:0]}
                                        : {{32{mem_rdata[31]}}, mem_rdata[31:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Mask stays unshifted; the LSU positions it using the low address bits.
    always_comb begin
        store_mask = 8'h00;
        case (size_q)
            2'd0:    store_mask = 8'h01;
            2'd1:    store_mask = 8'h03;
            2'd2:    store_mask = 8'h0F;
            default: store_mask = 8'hFF;
        endcase
    end

    assign in_access = (state == ACCESS);

    // Strobes are gated with reset so an access cut short by reset never
    // reaches memory. The single write strobe lands on the final ACCESS cycle.
    assign mem_ren   = reset && in_access && load_q;
    assign mem_wen   = reset && in_access && store_q && (cnt == 4'd0);
    assign mem_wmask = mem_wen ? store_mask : 8'h00;
    assign mem_raddr = in_access ? addr_q : 64'd0;
    assign mem_waddr = in_access ? addr_q : 64'd0;
    assign mem_wdata = (in_access && store_q) ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            rd_q         <= 5'd0;
            out_valid    <= 1'b0;
            out_data     <= 64'd0;
            out_rd       <= 5'd0;
            out_wen      <= 1'b0;
            out_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= in_addr;
                        wdata_q    <= in_wdata;
                        size_q     <= in_size;
                        unsigned_q <= in_unsigned;
                        load_q     <= req_load;
                        store_q    <= req_store;
                        rd_q       <= in_rd;
                        if (!(req_load || req_store)) begin
                            // Non-memory op: pass the ALU result straight through.
                            state        <= RESP;
                            out_valid    <= 1'b1;
                            out_data     <= in_addr;
                            out_rd       <= in_rd;
                            out_wen      <= (in_rd != 5'd0);
                            out_misalign <= 1'b0;
                        end else if (req_misalign) begin
                            // Misaligned: report the address, suppress writeback.
                            state        <= RESP;
                            out_valid    <= 1'b1;
                            out_data     <= in_addr;
                            out_rd       <= in_rd;
                            out_wen      <= 1'b0;
                            out_misalign <= 1'b1;
                        end else begin
                            state <= ACCESS;
                            cnt   <= CNT_INIT;
                        end
                    end
                end

                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state        <= RESP;
                        out_valid    <= 1'b1;
                        out_rd       <= rd_q;
                        out_misalign <= 1'b0;
                        if (load_q) begin
                            out_data <= load_ext;
                            out_wen  <= (rd_q != 5'd0);
                        end else begin
                            out_data <= 64'd0;
                            out_wen  <= 1'b0;
                        end
                    end
                end

                RESP: begin
                    // Packet is held untouched until WB takes it.
                    if (out_ready) begin
                        state        <= IDLE;
                        out_valid    <= 1'b0;
                        out_data     <= 64'd0;
                        out_rd       <= 5'd0;
                        out_wen      <= 1'b0;
                        out_misalign <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: directed self-checking bench for mem_access_ctrl at MEM_LAT 1, 3 and 4.
// Latency: n/a (bench).
// Backpressure: out_ready driven per instance to exercise RESP stalls.
module tb_mem_access_ctrl;

    localparam int NI = 3;

    logic        clock;
    logic        reset;

    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        in_is_load;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic [63:0] mem_rdata;

    logic        in_valid     [NI];
    logic        in_ready     [NI];
    logic [63:0] mem_raddr    [NI];
    logic        mem_ren      [NI];
    logic [63:0] mem_waddr    [NI];
    logic [63:0] mem_wdata    [NI];
    logic [7:0]  mem_wmask    [NI];
    logic        mem_wen      [NI];
    logic        out_valid    [NI];
    logic        out_ready    [NI];
    logic [63:0] out_data     [NI];
    logic [4:0]  out_rd       [NI];
    logic        out_wen      [NI];
    logic        out_misalign [NI];

    int checks   = 0;
    int failures = 0;
    int wen2_seen = 0;

    // Instance 0: MEM_LAT=1, instance 1: MEM_LAT=3, instance 2: MEM_LAT=4
    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_access_ctrl #(.MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
            .clock        (clock),
            .reset        (reset),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .in_addr      (in_addr),
            .in_wdata     (in_wdata),
            .in_is_load   (in_is_load),
            .in_is_store  (in_is_store),
            .in_size      (in_size),
            .in_unsigned  (in_unsigned),
            .in_rd        (in_rd),
            .mem_raddr    (mem_raddr[g]),
            .mem_rdata    (mem_rdata),
            .mem_ren      (mem_ren[g]),
            .mem_waddr    (mem_waddr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_wmask    (mem_wmask[g]),
            .mem_wen      (mem_wen[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .out_data     (out_data[g]),
            .out_rd       (out_rd[g]),
            .out_wen      (out_wen[g]),
            .out_misalign (out_misalign[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write strobes on the MEM_LAT=4 instance are only ever expected from
    // the post-reset traffic, which contains no stores.
    always @(negedge clock) begin
        if (mem_wen[2] === 1'b1) wen2_seen <= wen2_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one edge; returns in cycle T+1.
    task automatic issue(input int i, input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd);
        in_addr     = addr;
        in_wdata    = wd;
        in_is_load  = ld;
        in_is_store = st;
        in_size     = sz;
        in_unsigned = uns;
        in_rd       = rd;
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wcnt;
        logic [7:0] idle_mask;
        reset       = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_size     = 2'd0;
        in_unsigned = 1'b0;
        in_rd       = 5'd0;
        mem_rdata   = '0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  in_ready[0],     0);
        chk("rst_out_valid", out_valid[0],    0);
        chk("rst_mem_ren",   mem_ren[0],      0);
        chk("rst_mem_wen",   mem_wen[0],      0);
        chk("rst_wmask",     mem_wmask[0],    0);
        chk("rst_out_data",  out_data[0],     0);
        chk("rst_misalign",  out_misalign[0], 0);
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready[0], 1);

        // LB signed, MEM_LAT=1
        mem_rdata = 64'h80;
        issue(0, 1, 0, 2'd0, 0, 64'h8000_0003, 0, 5'd3);
        chk("lb_ren",       mem_ren[0],   1);
        chk("lb_raddr",     mem_raddr[0], 64'h8000_0003);
        chk("lb_in_ready",  in_ready[0],  0);
        chk("lb_valid_t1",  out_valid[0], 0);
        tick();
        chk("lb_valid_t2",  out_valid[0], 1);
        chk("lb_data",      out_data[0],  64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_wen",       out_wen[0],   1);
        chk("lb_rd",        out_rd[0],    3);
        chk("lb_ren_resp",  mem_ren[0],   0);
        tick();
        chk("lb_done",      out_valid[0], 0);
        chk("lb_ready_back", in_ready[0], 1);

        // LBU
        issue(0, 1, 0, 2'd0, 1, 64'h8000_0003, 0, 5'd3);
        tick();
        chk("lbu_data", out_data[0], 64'h80);
        tick();

        // LW signed, aligned
        mem_rdata = 64'h1234_5678_8000_0000;
        issue(0, 1, 0, 2'd2, 0, 64'h8000_0004, 0, 5'd9);
        tick();
        chk("lw_data", out_data[0], 64'hFFFF_FFFF_8000_0000);
        tick();

        // Load+store flags together behave as a load
        mem_rdata = 64'h7F;
        issue(0, 1, 1, 2'd0, 0, 64'h10, 64'hFF, 5'd4);
        chk("ldst_ren", mem_ren[0], 1);
        chk("ldst_wen", mem_wen[0], 0);
        tick();
        chk("ldst_data", out_data[0], 64'h7F);
        chk("ldst_owen", out_wen[0],  1);
        tick();

        // Misaligned LW: no access, out_valid at T+1
        issue(0, 1, 0, 2'd2, 0, 64'h8000_0002, 0, 5'd6);
        chk("mis_valid", out_valid[0],    1);
        chk("mis_flag",  out_misalign[0], 1);
        chk("mis_owen",  out_wen[0],      0);
        chk("mis_data",  out_data[0],     64'h8000_0002);
        chk("mis_ren",   mem_ren[0],      0);
        chk("mis_wen",   mem_wen[0],      0);
        tick();
        chk("mis_clear", out_misalign[0], 0);

        // SH on MEM_LAT=3: exactly one strobe, in the last ACCESS cycle
        issue(1, 0, 1, 2'd1, 0, 64'h8000_0006, 64'h1234, 5'd2);
        chk("sh_wdata", mem_wdata[1], 64'h1234_0000_0000_0000);
        chk("sh_waddr", mem_waddr[1], 64'h8000_0006);
        wcnt = 0;
        idle_mask = 8'h00;
        for (int k = 0; k < 3; k++) begin
            chk("sh_no_valid", out_valid[1], 0);
            if (mem_wen[1]) begin
                wcnt++;
                chk("sh_wmask", mem_wmask[1], 8'h03);
                chk("sh_strobe_last", k, 2);
            end else begin
                idle_mask = idle_mask | mem_wmask[1];
            end
            tick();
        end
        chk("sh_wen_count", wcnt,         1);
        chk("sh_idle_mask", idle_mask,    0);
        chk("sh_valid",     out_valid[1], 1);
        chk("sh_owen",      out_wen[1],   0);
        chk("sh_odata",     out_data[1],  0);
        chk("sh_wen_resp",  mem_wen[1],   0);
        tick();

        // LD on MEM_LAT=3 with a 4-cycle WB stall
        out_ready[1] = 1'b0;
        mem_rdata = 64'hF123_4567_89AB_CDEF;
        issue(1, 1, 0, 2'd3, 1, 64'h8000_0008, 0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            chk("ld_ren",      mem_ren[1],   1);
            chk("ld_no_valid", out_valid[1], 0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("ld_stall_valid", out_valid[1], 1);
            chk("ld_stall_data",  out_data[1],  64'hF123_4567_89AB_CDEF);
            chk("ld_stall_ready", in_ready[1],  0);
            chk("ld_stall_ren",   mem_ren[1],   0);
            if (k == 0) mem_rdata = 64'h0;
            tick();
        end
        chk("ld_owen", out_wen[1], 1);
        out_ready[1] = 1'b1;
        chk("ld_hold_valid", out_valid[1], 1);
        chk("ld_hold_ready", in_ready[1],  0);
        tick();
        chk("ld_release_valid", out_valid[1], 0);
        chk("ld_release_ready", in_ready[1],  1);

        // SD on MEM_LAT=4, reset asserted in the 2nd ACCESS cycle
        issue(2, 0, 1, 2'd3, 0, 64'h8000_0010, 64'hCAFE, 5'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("sd_rst_wen",   mem_wen[2],  0);
        chk("sd_rst_ready", in_ready[2], 0);
        tick();
        chk("sd_after_wen",   mem_wen[2],   0);
        chk("sd_after_valid", out_valid[2], 0);
        chk("sd_after_wdata", mem_wdata[2], 0);
        chk("sd_after_raddr", mem_raddr[2], 0);
        chk("sd_after_odata", out_data[2],  0);
        reset = 1'b1;
        #1;
        chk("sd_release_ready", in_ready[2], 1);
        for (int k = 0; k < 5; k++) begin
            chk("sd_no_stale_valid", out_valid[2], 0);
            tick();
        end

        // Non-mem ops, fresh after reset on MEM_LAT=4
        issue(2, 0, 0, 2'd0, 0, 64'hDEAD, 0, 5'd5);
        chk("alu_valid", out_valid[2], 1);
        chk("alu_data",  out_data[2],  64'hDEAD);
        chk("alu_wen",   out_wen[2],   1);
        chk("alu_rd",    out_rd[2],    5);
        tick();
        issue(2, 0, 0, 2'd0, 0, 64'hDEAD, 0, 5'd0);
        chk("alu_rd0_valid", out_valid[2], 1);
        chk("alu_rd0_wen",   out_wen[2],   0);
        tick();
        chk("sd_wen_never", wen2_seen, 0);

        // Non-mem op on MEM_LAT=1 as well
        issue(0, 0, 0, 2'd3, 0, 64'hDEAD, 0, 5'd5);
        chk("alu0_data", out_data[0], 64'hDEAD);
        chk("alu0_wen",  out_wen[0],  1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
